// File: rtl/main_alu_pkg.sv
// rtl/main_alu_pkg.sv - shared op encodings, display selects and operand table for the ALU lab
package main_alu_pkg;

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_OR  = 3'd1;
    localparam logic [2:0] OP_XOR = 3'd2;
    localparam logic [2:0] OP_NOR = 3'd3;
    localparam logic [2:0] OP_ADD = 3'd4;
    localparam logic [2:0] OP_SUB = 3'd5;
    localparam logic [2:0] OP_SLT = 3'd6;
    localparam logic [2:0] OP_SLL = 3'd7;

    localparam logic [2:0] DISP_BYTE0 = 3'd0;
    localparam logic [2:0] DISP_BYTE1 = 3'd1;
    localparam logic [2:0] DISP_BYTE2 = 3'd2;
    localparam logic [2:0] DISP_BYTE3 = 3'd3;

    localparam logic [31:0] OPERAND_A [0:7] = '{
        32'h0000_0000, 32'h0000_0003, 32'h8000_0000, 32'h7FFF_FFFF,
        32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h1234_5678
    };

    localparam logic [31:0] OPERAND_B [0:7] = '{
        32'h0000_0000, 32'h0000_0607, 32'h8000_0000, 32'h7FFF_FFFF,
        32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h3333_3333
    };

endpackage

// File: rtl/alu32.sv
// rtl/alu32.sv - combinational 32-bit, 8-operation ALU with zero and overflow flags
module alu32
    import main_alu_pkg::*;
(
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  op,
    output logic [31:0] F,
    output logic        ZF,
    output logic        OF
);

    logic [31:0] sum;
    logic [31:0] diff;
    logic        of_add;
    logic        of_sub;

    assign sum    = A + B;
    assign diff   = A - B;
    assign of_add = (A[31] == B[31]) && (sum[31] != A[31]);
    assign of_sub = (A[31] != B[31]) && (diff[31] != A[31]);

    always_comb begin
        F  = 32'h0;
        OF = 1'b0;
        case (op)
            OP_AND: F = A & B;
            OP_OR:  F = A | B;
            OP_XOR: F = A ^ B;
            OP_NOR: F = ~(A | B);
            OP_ADD: begin
                F  = sum;
                OF = of_add;
            end
            OP_SUB: begin
                F  = diff;
                OF = of_sub;
            end
            // Sign of the difference is wrong on overflow, so use the true signed compare.
            OP_SLT: F = {31'h0, $signed(A) < $signed(B)};
            OP_SLL: F = B << A[4:0];
            default: F = 32'h0;
        endcase
    end

    assign ZF = (F == 32'h0);

endmodule

// File: rtl/main_alu_display.sv
// rtl/main_alu_display.sv - ALU lab top: operand ROM, ALU, display mux and LED register
module main_alu_display
    import main_alu_pkg::*;
(
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [2:0] ALU_OP,
    input  logic [2:0] AB_SW,
    input  logic [2:0] F_LED_SW,
    output logic [7:0] LED
);

    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] f;
    logic        zf;
    logic        of;
    logic [7:0]  led_next;

    assign a = OPERAND_A[AB_SW];
    assign b = OPERAND_B[AB_SW];

    alu32 u_alu (
        .A  (a),
        .B  (b),
        .op (ALU_OP),
        .F  (f),
        .ZF (zf),
        .OF (of)
    );

    always_comb begin
        led_next = {6'b0, of, zf};
        case (F_LED_SW)
            DISP_BYTE0: led_next = f[7:0];
            DISP_BYTE1: led_next = f[15:8];
            DISP_BYTE2: led_next = f[23:16];
            DISP_BYTE3: led_next = f[31:24];
            default:    led_next = {6'b0, of, zf};
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            LED <= 8'h00;
        end else begin
            LED <= led_next;
        end
    end

endmodule

// File: tb/tb_main_alu_display.sv
// tb/tb_main_alu_display.sv - scoreboard bench for main_alu_display
module tb_main_alu_display;

    logic       CLK;
    logic       RST_N;
    logic [2:0] ALU_OP;
    logic [2:0] AB_SW;
    logic [2:0] F_LED_SW;
    logic [7:0] LED;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  exp_q [$];
    string       tag_q [$];

    main_alu_display dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .ALU_OP   (ALU_OP),
        .AB_SW    (AB_SW),
        .F_LED_SW (F_LED_SW),
        .LED      (LED)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%02h expected=0x%02h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] model(input logic [2:0] op, input logic [2:0] ab, input logic [2:0] sel);
        logic [31:0] ta [8];
        logic [31:0] tb [8];
        logic [31:0] a, b, f;
        logic [32:0] wide;
        logic        ov;
        ta = '{32'h0, 32'h3, 32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h12345678};
        tb = '{32'h0, 32'h607, 32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h33333333};
        a = ta[ab];
        b = tb[ab];
        ov = 1'b0;
        wide = 33'h0;
        case (op)
            3'd0: f = a & b;
            3'd1: f = a | b;
            3'd2: f = a ^ b;
            3'd3: f = ~a & ~b;
            3'd4: begin
                wide = {a[31], a} + {b[31], b};
                f = wide[31:0];
                ov = wide[32] ^ wide[31];
            end
            3'd5: begin
                wide = {a[31], a} - {b[31], b};
                f = wide[31:0];
                ov = wide[32] ^ wide[31];
            end
            3'd6: begin
                wide = {a[31], a} - {b[31], b};
                f = {31'h0, wide[32]};
            end
            default: f = b << a[4:0];
        endcase
        case (sel)
            3'd0: return f[7:0];
            3'd1: return f[15:8];
            3'd2: return f[23:16];
            3'd3: return f[31:24];
            default: return {6'b0, ov, (f == 32'h0)};
        endcase
    endfunction

    // Drive between edges, then score the register one edge later.
    task automatic apply(input string tag, input logic [2:0] op, input logic [2:0] ab,
                         input logic [2:0] sel, input logic [7:0] exp);
        @(negedge CLK);
        ALU_OP   = op;
        AB_SW    = ab;
        F_LED_SW = sel;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(posedge CLK);
        #1;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 8'h01, 8'h00);
        end else begin
            check(tag_q.pop_front(), LED, exp_q.pop_front());
        end
    endtask

    initial begin
        RST_N    = 1'b1;
        ALU_OP   = 3'd0;
        AB_SW    = 3'd0;
        F_LED_SW = 3'd0;
        #2;
        RST_N = 1'b0;
        #1;
        check("reset_async", LED, 8'h00);
        repeat (2) @(posedge CLK);
        #1;
        check("reset_hold", LED, 8'h00);
        @(negedge CLK);
        RST_N = 1'b1;

        apply("add_b3", 3'd4, 3'd3, 3'd3, 8'hFF);
        apply("add_b2", 3'd4, 3'd3, 3'd2, 8'hFF);
        apply("add_b1", 3'd4, 3'd3, 3'd1, 8'hFF);
        apply("add_b0", 3'd4, 3'd3, 3'd0, 8'hFE);
        apply("add_flags", 3'd4, 3'd3, 3'd4, 8'h02);
        apply("xor_b3", 3'd2, 3'd6, 3'd3, 8'h7F);
        apply("xor_b2", 3'd2, 3'd6, 3'd2, 8'hFF);
        apply("xor_b1", 3'd2, 3'd6, 3'd1, 8'hFF);
        apply("xor_b0", 3'd2, 3'd6, 3'd0, 8'hFF);
        apply("xor_flags", 3'd2, 3'd6, 3'd4, 8'h00);
        apply("sub_zero_flags", 3'd5, 3'd4, 3'd4, 8'h01);
        apply("sub_b3", 3'd5, 3'd5, 3'd3, 8'h80);
        apply("sub_b0", 3'd5, 3'd5, 3'd0, 8'h01);
        apply("slt_true", 3'd6, 3'd5, 3'd0, 8'h01);
        apply("slt_false", 3'd6, 3'd6, 3'd0, 8'h00);
        apply("sll_b1", 3'd7, 3'd1, 3'd1, 8'h30);
        apply("sll_b0", 3'd7, 3'd1, 3'd0, 8'h38);
        apply("add_zf_of", 3'd4, 3'd2, 3'd4, 8'h03);

        for (int i = 0; i < 48; i++) begin
            logic [2:0] op, ab, sel;
            op  = 3'($urandom_range(0, 7));
            ab  = 3'($urandom_range(0, 7));
            sel = 3'($urandom_range(0, 7));
            apply($sformatf("rand_op%0d_ab%0d_sel%0d", op, ab, sel), op, ab, sel, model(op, ab, sel));
        end

        apply("pre_reset", 3'd4, 3'd3, 3'd0, 8'hFE);
        #2;
        RST_N = 1'b0;
        #1;
        check("midrun_reset_async", LED, 8'h00);
        @(posedge CLK);
        #1;
        check("midrun_reset_hold", LED, 8'h00);
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        check("reset_release", LED, 8'hFE);

        check("scoreboard_drained", 8'(exp_q.size()), 8'h00);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/main_alu_display.md
# main_alu_display

Board-level ALU demonstrator: a 32-bit, 8-operation ALU is driven by operand pairs taken from an 8-entry constant table. Switches select the operation, the operand pair, and which byte of the result (or the flag byte) is shown on 8 LEDs. The block is the top level of the ALU lab design and sits directly on switches and LEDs.

## Interface
- No parameters; data width is fixed at 32 bits.
- CLK  in  1  system clock; all state changes on its rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- ALU_OP  in  3  operation select.
- AB_SW  in  3  operand-pair select.
- F_LED_SW  in  3  display select.
- LED  out  8  registered display byte.

## Operation
- Operand table (AB_SW -> A, B):
  - 0 -> 0x00000000, 0x00000000
  - 1 -> 0x00000003, 0x00000607
  - 2 -> 0x80000000, 0x80000000
  - 3 -> 0x7FFFFFFF, 0x7FFFFFFF
  - 4 -> 0xFFFFFFFF, 0xFFFFFFFF
  - 5 -> 0x80000000, 0xFFFFFFFF
  - 6 -> 0xFFFFFFFF, 0x80000000
  - 7 -> 0x12345678, 0x33333333
- ALU_OP -> F:
  - 0: A & B
  - 1: A | B
  - 2: A ^ B
  - 3: ~(A | B)
  - 4: A + B, mod 2^32
  - 5: A - B, mod 2^32
  - 6: signed A < B ? 1 : 0
  - 7: B << A[4:0], logical; A[31:5] ignored
- Flags:
  - ZF = (F == 0) for every op.
  - OF = signed two's-complement overflow for ops 4 and 5.
    - ADD: A and B have the same sign and F differs from it.
    - SUB: A and B have different signs and F's sign differs from A's.
  - OF = 0 for all other ops.
  - SLT compares correctly even when A - B overflows.
- Display mux (F_LED_SW -> next LED):
  - 0: F[7:0]
  - 1: F[15:8]
  - 2: F[23:16]
  - 3: F[31:24]
  - 4..7: {6'b0, OF, ZF}

## Timing
- Operand lookup, ALU and display mux are purely combinational.
- LED is a single 8-bit register loaded every rising CLK edge with the mux output.
- Latency: one clock from any switch change to LED.
- Switches are assumed stable or externally synchronized; there is no debouncing.
- Reset:
  - RST_N low clears LED to 0x00 immediately, without waiting for a clock edge.
  - LED holds 0x00 while RST_N is low.
  - The first edge after RST_N rises loads the current selection.
  - Asserting reset mid-operation discards the current display; there is no other state.
- Simultaneous changes of all three selects take effect together on the next edge.

## Structure
- Shared package `main_alu_pkg`:
  - ALU_OP encodings as named constants: OP_AND, OP_OR, OP_XOR, OP_NOR, OP_ADD, OP_SUB, OP_SLT, OP_SLL.
  - Display-select constants.
  - The 8-entry operand table.
- Sub-module `alu32`:
  - Inputs: A[31:0], B[31:0], op[2:0].
  - Outputs: F[31:0], ZF, OF.
  - Fully combinational.
- Top level: operand ROM, alu32 instance, display mux, LED register.

## Test plan
- ALU_OP=4, AB_SW=3, F_LED_SW stepped 3, 2, 1, 0 -> LED = 0xFF, 0xFF, 0xFF, 0xFE one clock after each step; F_LED_SW=4 -> LED = 0x02 (OF=1, ZF=0).
- ALU_OP=2, AB_SW=6, F_LED_SW stepped 3, 2, 1, 0 -> LED = 0x7F, 0xFF, 0xFF, 0xFF; F_LED_SW=4 -> 0x00.
- ALU_OP=5, AB_SW=4, F_LED_SW=4 -> LED = 0x01 (F=0, ZF=1, OF=0); ALU_OP=5, AB_SW=5, F_LED_SW=3 -> 0x80, then F_LED_SW=0 -> 0x01.
- ALU_OP=6, AB_SW=5, F_LED_SW=0 -> LED = 0x01 (signed -2^31 < -1); ALU_OP=6, AB_SW=6 -> 0x00.
- ALU_OP=7, AB_SW=1, F_LED_SW=1 -> LED = 0x30, F_LED_SW=0 -> 0x38 (0x607<<3 = 0x3038); ALU_OP=4, AB_SW=2, F_LED_SW=4 -> 0x03 (F=0, ZF=1, OF=1).
- Reset: drive selection giving 0xFE, pull RST_N low between clock edges -> LED = 0x00 immediately and held; release -> 0xFE after the next rising edge.
